// File: rtl/vdp_tile_fetch.sv
// Graphics-I tile fetcher/renderer: name, pattern and colour fetch over VRAM req/ack, 2x2 magnified output.
// Optional: define VDP_UNDERRUN_CNT_EN to add the saturating underrun_cnt output.
module vdp_tile_fetch #(
  parameter int HVID_BEGIN = 64,
  parameter int VVID_BEGIN = 48,
  parameter int HC_BITS    = 10,
  parameter int VC_BITS    = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [HC_BITS-1:0] col,
  input  logic [VC_BITS-1:0] row,
  input  logic               vid_active,
  input  logic               bdr_active,
  input  logic               end_of_frame,
  input  logic [3:0]         name_base,
  input  logic [2:0]         pat_base,
  input  logic [7:0]         color_base,
  input  logic [3:0]         backdrop,
  output logic               vram_req,
  output logic [13:0]        vram_addr,
  input  logic               vram_ack,
  input  logic [7:0]         vram_data,
  output logic [3:0]         color,
  output logic               underrun
`ifdef VDP_UNDERRUN_CNT_EN
  ,
  output logic [7:0]         underrun_cnt
`endif
);

  typedef enum logic [2:0] {IDLE, NAME, PAT, COLR, DONE} fetch_state_t;

  localparam logic [HC_BITS-1:0] LINE_START_COL = HC_BITS'(HVID_BEGIN - 17);
  localparam logic [HC_BITS-1:0] FIRST_LOAD_COL = HC_BITS'(HVID_BEGIN - 1);
  localparam logic [VC_BITS-1:0] VBEGIN         = VC_BITS'(VVID_BEGIN);

  fetch_state_t state, state_n;
  logic         req_n;
  logic [13:0]  addr_n;
  logic [7:0]   name_q, name_n, pat_q, pat_n, clr_q, clr_n;
  logic         discard, discard_n, pend_valid, pend_valid_n;
  logic [4:0]   pend_tx, pend_tx_n;
  logic         load_tile, load_blank, underrun_evt, fetch_go;
  logic [4:0]   fetch_tx;

  logic [VC_BITS-1:0] ydiff;
  logic [7:0]         y;
  logic               active_row;
  logic [HC_BITS-1:0] cm;
  logic               strobe, line_start, last_tile;
  logic [4:0]         k;

  // Wrapping subtraction makes rows/cols before the window compare as huge values.
  assign ydiff      = row - VBEGIN;
  assign y          = ydiff[8:1];
  assign active_row = ydiff < VC_BITS'(384);
  assign cm         = col - FIRST_LOAD_COL;
  assign strobe     = active_row && (cm < HC_BITS'(512)) && (cm[3:0] == 4'd0);
  assign k          = cm[8:4];
  assign last_tile  = (k == 5'd31);
  // Tile 0 sits in NAME while col = HVID_BEGIN-16, giving it the same 16-cycle window as later tiles.
  assign line_start = active_row && (col == LINE_START_COL);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      vram_req   <= 1'b0;
      vram_addr  <= '0;
      name_q     <= '0;
      pat_q      <= '0;
      clr_q      <= '0;
      discard    <= 1'b0;
      pend_valid <= 1'b0;
      pend_tx    <= '0;
    end else begin
      state      <= state_n;
      vram_req   <= req_n;
      vram_addr  <= addr_n;
      name_q     <= name_n;
      pat_q      <= pat_n;
      clr_q      <= clr_n;
      discard    <= discard_n;
      pend_valid <= pend_valid_n;
      pend_tx    <= pend_tx_n;
    end
  end

  always_comb begin
    state_n      = state;
    req_n        = vram_req;
    addr_n       = vram_addr;
    name_n       = name_q;
    pat_n        = pat_q;
    clr_n        = clr_q;
    discard_n    = discard;
    pend_valid_n = pend_valid;
    pend_tx_n    = pend_tx;
    load_tile    = 1'b0;
    load_blank   = 1'b0;
    underrun_evt = 1'b0;
    fetch_go     = 1'b0;
    fetch_tx     = '0;

    unique case (state)
      IDLE: if (line_start) fetch_go = 1'b1;
      NAME: if (vram_ack) begin
        name_n  = vram_data;
        state_n = PAT;
        addr_n  = {pat_base, vram_data, y[2:0]};
      end
      PAT: if (vram_ack) begin
        pat_n   = vram_data;
        state_n = COLR;
        addr_n  = {color_base, 1'b0, name_q[7:3]};
      end
      COLR: if (vram_ack) begin
        clr_n = vram_data;
        req_n = 1'b0;
        if (discard) begin
          discard_n = 1'b0;
          state_n   = IDLE;
          if (pend_valid) begin
            fetch_go     = 1'b1;
            fetch_tx     = pend_tx;
            pend_valid_n = 1'b0;
          end
        end else begin
          state_n = DONE;
        end
      end
      DONE: ;
      default: state_n = IDLE;
    endcase

    if (strobe) begin
      if (state == DONE) begin
        load_tile = 1'b1;
        state_n   = IDLE;
        fetch_go  = !last_tile;
        fetch_tx  = k + 5'd1;
      end else begin
        underrun_evt = 1'b1;
        load_blank   = 1'b1;
        // Nothing left on the bus: go for the next tile now; otherwise let the handshake drain first.
        if (state == IDLE || (state == COLR && vram_ack)) begin
          discard_n    = 1'b0;
          pend_valid_n = 1'b0;
          req_n        = 1'b0;
          state_n      = IDLE;
          fetch_go     = !last_tile;
          fetch_tx     = k + 5'd1;
        end else begin
          discard_n    = 1'b1;
          pend_valid_n = !last_tile;
          pend_tx_n    = k + 5'd1;
        end
      end
    end

    if (fetch_go) begin
      state_n = NAME;
      req_n   = 1'b1;
      addr_n  = {name_base, y[7:3], fetch_tx};
    end
  end

  logic [7:0] sh_pat, sh_clr;
  logic [3:0] pix_nib, pix, color_n;

  assign pix_nib = sh_pat[7] ? sh_clr[7:4] : sh_clr[3:0];
  assign pix     = (pix_nib == 4'd0) ? backdrop : pix_nib;
  assign color_n = vid_active ? pix : (bdr_active ? backdrop : '0);

  // Shift at the end of each 2-px pair; cm is even on the second px of a pair.
  always_ff @(posedge clk) begin
    if (reset) begin
      sh_pat <= '0;
      sh_clr <= '0;
      color  <= '0;
    end else begin
      if (load_tile) begin
        sh_pat <= pat_q;
        sh_clr <= clr_q;
      end else if (load_blank) begin
        sh_pat <= '0;
        sh_clr <= '0;
      end else if (vid_active && !cm[0]) begin
        sh_pat <= {sh_pat[6:0], 1'b0};
      end
      color <= color_n;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)             underrun <= 1'b0;
    else if (underrun_evt) underrun <= 1'b1;
    else if (end_of_frame) underrun <= 1'b0;
  end

`ifdef VDP_UNDERRUN_CNT_EN
  always_ff @(posedge clk) begin
    if (reset)                                 underrun_cnt <= '0;
    else if (underrun_evt && underrun_cnt != 8'hFF) underrun_cnt <= underrun_cnt + 8'd1;
  end
`endif

endmodule
